// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Stall/flush sequencer for the 5-stage RV64 pipeline. It resolves three hazards:
//   - load-use dependencies between ID and a load in EX,
//   - taken branches resolved in EX,
//   - multi-cycle data-memory accesses, with a bounded wait.
// The pipeline controls are combinational from the state, the inputs and rst_n.
// The state, the wait counter, mem_error and the performance counters are registered.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memRead,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_bubble,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // The wait counter must be able to hold the value MEM_TIMEOUT itself.
  localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ZERO = '0;
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_error_q, mem_error_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;

  logic load_use_s;
  logic mem_stall_s;
  logic wait_expired_s;
  logic branch_flush_s;

  // Hazard decode: load-use against the ID operands (x0 never hazards), a fresh memory
  // stall, wait expiry, and a branch flush that is not preempted by memory.
  always_comb begin
    load_use_s     = ex_memRead && (ex_rd != 5'd0) &&
                     ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                      (id_uses_rs2 && (id_rs2 == ex_rd)));
    mem_stall_s    = mem_req && !mem_ready;
    wait_expired_s = (state_q == ST_MEM_WAIT) && !mem_ready && (wait_q == TIMEOUT_V);
    branch_flush_s = (state_q == ST_RUN) && !mem_stall_s && branch_taken;
  end

  // State, wait counter and sticky error register with async clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      wait_q      <= WAIT_ZERO;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      mem_error_q <= mem_error_d;
    end
  end

  // Next-state logic. Entry to MEM_WAIT sets the wait counter to 1; when the counter
  // reaches MEM_TIMEOUT the access is abandoned, which sets the sticky error bit.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    mem_error_d = mem_error_q;
    case (state_q)
      ST_RUN: begin
        if (mem_stall_s) begin
          state_d = ST_MEM_WAIT;
          wait_d  = WAIT_ONE;
        end else begin
          state_d = ST_RUN;
          wait_d  = WAIT_ZERO;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          state_d = ST_RUN;
          wait_d  = WAIT_ZERO;
        end else if (wait_q == TIMEOUT_V) begin
          state_d     = ST_RUN;
          wait_d      = WAIT_ZERO;
          mem_error_d = 1'b1;
        end else begin
          state_d = ST_MEM_WAIT;
          wait_d  = wait_q + WAIT_ONE;
        end
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = WAIT_ZERO;
      end
    endcase
  end

  // Pipeline control decode.
  // Priority is reset > memory stall > branch flush > load-use > free flow.
  always_comb begin
    pc_write      = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_en     = 1'b1;
    mem_wb_bubble = 1'b0;
    if (!rst_n) begin
      pc_write      = 1'b0;
      if_id_en      = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_en      = 1'b0;
      id_ex_flush   = 1'b1;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mem_stall_s) begin
            // Freeze everything upstream of MEM; MEM/WB takes a bubble.
            pc_write      = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
          end else if (branch_taken) begin
            // Load target PC and discard the two wrong-path instructions.
            // This also covers a coincident load-use, since the ID instruction is dropped.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use_s) begin
            // Hold IF and ID for one cycle and send a bubble into EX.
            // The load itself moves on to MEM.
            pc_write    = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end else begin
            pc_write = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ready) begin
            // Release: MEM/WB captures the memory result.
            mem_wb_bubble = 1'b0;
          end else if (wait_q == TIMEOUT_V) begin
            // Abandon the access: let the pipe move, but keep the result out of WB.
            mem_wb_bubble = 1'b1;
          end else begin
            pc_write      = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
          end
        end
        default: begin
          pc_write      = 1'b0;
          if_id_en      = 1'b0;
          id_ex_en      = 1'b0;
          ex_mem_en     = 1'b0;
          mem_wb_bubble = 1'b1;
        end
      endcase
    end
  end

  // Saturating performance counter next values.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_write && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_ONE;
    end else begin
      stall_d = stall_q;
    end
    if (branch_flush_s && (flush_q != CNT_MAX)) begin
      flush_d = flush_q + CNT_ONE;
    end else begin
      flush_d = flush_q;
    end
  end

  // Performance counter registers with async clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign mem_error   = mem_error_q;
  assign stall_count = stall_q;
  assign flush_count = flush_q;

  // wait_expired_s is kept as a named decode term alongside the others.
  logic unused_s;
  assign unused_s = wait_expired_s;

endmodule
